mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesting ports (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, a power of two, at least 32.
REQ-004 SHALL have parameter RD_LAT, default 1: memory read latency in cycles (1..4).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_PORTS bits: per-port request pending.
REQ-008 SHALL have port req_ready, output, NUM_PORTS bits: per-port request accepted this cycle.
REQ-009 SHALL have port req_wr, input, NUM_PORTS bits: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, NUM_PORTS*ADDR_W bits: packed byte addresses.
REQ-011 SHALL have port req_wdata, input, NUM_PORTS*DATA_W bits: packed write data.
REQ-012 SHALL have port req_size, input, NUM_PORTS*3 bits: transfer size; 3'd1 = byte, 3'd2 = half, 3'd4 = word.
REQ-013 SHALL have port rsp_valid, output, NUM_PORTS bits: one-cycle completion pulse per port.
REQ-014 SHALL have port rsp_rdata, output, DATA_W bits: read data, shared by all ports.
REQ-015 SHALL have port rsp_err, output, 1 bit: error flag, qualified by rsp_valid.
REQ-016 SHALL have ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_size (3), mem_rd_en (1) and mem_wr_en (1), all outputs: the memory side.
REQ-017 SHALL have port mem_rdata, input, DATA_W bits: memory read data.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE, req_ready SHALL be one-hot on the round-robin winner among the set req_valid bits; it SHALL be zero in every other state.
- Acceptance = req_valid & req_ready. On acceptance the block latches port index, wr, addr, wdata and size, then goes to ISSUE.
REQ-020 Round-robin: after a grant to port i, priority SHALL start at (i+1) mod NUM_PORTS; after reset, port 0 has highest priority.
REQ-021 A request SHALL be illegal when size is not 1, 2 or 4, or when the address is misaligned (half: addr[0]≠0; word: addr[1:0]≠0).
- Illegal request: ISSUE asserts no memory enable and goes to RESP with rsp_err=1.
REQ-022 A legal request in ISSUE SHALL assert exactly one of mem_rd_en / mem_wr_en for exactly one cycle, with mem_addr, mem_wdata and mem_size driven from the latches.
REQ-023 Writes SHALL go ISSUE→RESP; reads SHALL go ISSUE→WAIT.
- WAIT lasts RD_LAT-1 cycles, then RESP.
- mem_rdata SHALL be captured exactly RD_LAT cycles after the mem_rd_en cycle.
REQ-024 RESP SHALL pulse rsp_valid for one cycle on the latched port only, with the following, then return to IDLE:
- rsp_rdata = captured data for a read, 0 otherwise;
- rsp_err as determined by REQ-021.
REQ-025 Latency, with acceptance at cycle t:
- legal write: rsp_valid at t+2;
- legal read: rsp_valid at t+2+RD_LAT-1;
- illegal request: rsp_valid at t+2.
REQ-026 No new request SHALL be accepted before the RESP cycle completes, so at most one transaction is outstanding.
REQ-027 When mem_rd_en and mem_wr_en are low, mem_addr, mem_wdata and mem_size SHALL be 0.
REQ-028 Dropping req_valid on a port that has not been accepted SHALL be legal and SHALL leave the round-robin pointer unchanged.

Reset
REQ-029 On Reset low, asynchronously, all of the following SHALL hold:
- FSM state = IDLE;
- round-robin pointer = 0;
- latency counter and all latches = 0;
- req_ready, rsp_valid, rsp_rdata, rsp_err and all mem_* outputs = 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it: no rsp_valid is produced, and a pending memory enable is not re-issued.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the size encodings (SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4) and the FSM state enum.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-033 With RD_LAT=2: port 0 reads a word at 0x10 with memory returning 0xDEADBEEF; accepted at t -> mem_rd_en at t+1, rsp_valid[0] at t+3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-034 Ports 0 and 1 both hold req_valid continuously with writes -> grants alternate 0,1,0,1, and each rsp_valid arrives 2 cycles after its acceptance.
REQ-035 Port 1 requests a word read at 0x13 -> no mem_rd_en; rsp_valid[1] with rsp_err=1 at t+2. Port 0 requests size 3'd3 -> rsp_err=1.
REQ-036 Reset driven low while in WAIT -> all outputs 0 immediately; after release, no stale rsp_valid, and the next grant goes to port 0.
REQ-037 With NUM_PORTS=4, all ports requesting, 8 transactions -> grant order 0,1,2,3,0,1,2,3, and req_ready is never asserted outside IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and FSM state type for the memory arbiter
package mem_arb_pkg;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_rr_arbiter.sv
// rtl/mem_arb_rr_arbiter.sv - round-robin one-hot grant starting at a priority pointer
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-outstanding round-robin arbiter from N request ports to one memory
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*3-1:0]      req_size,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [2:0]                  mem_size,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int         PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [1:0] CNT_LAST = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]    port_q, port_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          size_q, size_d;
    logic                err_q, err_d;

    logic [NUM_PORTS-1:0] gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [2:0]           sel_size;
    logic                 issue_en;
    logic [NUM_PORTS-1:0] port_onehot;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign sel_wr    = req_wr[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign sel_size  = req_size[gnt_idx*3 +: 3];

    // Gated with Reset so ready stays low while reset is held, even with requests pending.
    assign req_ready = (state_q == IDLE && Reset) ? gnt : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    port_d  = gnt_idx;
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    size_d  = sel_size;
                    err_d   = ~req_legal(sel_size, sel_addr[1:0]);
                    ptr_d   = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (err_q || wr_q || RD_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) state_d = RESP;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            port_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    assign issue_en  = (state_q == ISSUE) && !err_q;
    assign mem_rd_en = issue_en && !wr_q;
    assign mem_wr_en = issue_en && wr_q;
    assign mem_addr  = issue_en ? addr_q  : '0;
    assign mem_wdata = issue_en ? wdata_q : '0;
    assign mem_size  = issue_en ? size_q  : '0;

    always_comb begin
        port_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_q == PTR_W'(i)) port_onehot[i] = 1'b1;
        end
    end

    // Read data is valid on mem_rdata during the RESP cycle, RD_LAT cycles after the enable.
    assign rsp_valid = (state_q == RESP) ? port_onehot : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = (state_q == RESP && !wr_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb with 4 ports and RD_LAT=2
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int NP = 4;
    localparam int RL = 2;

    logic            CLK = 1'b0;
    logic            Reset;
    logic [NP-1:0]   req_valid, req_ready, req_wr, rsp_valid;
    logic [NP*32-1:0] req_addr, req_wdata;
    logic [NP*3-1:0] req_size;
    logic [31:0]     rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic            rsp_err, mem_rd_en, mem_wr_en;
    logic [2:0]      mem_size;

    mem_arb #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .RD_LAT(RL)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    logic [NP-1:0] tv, twr;
    logic [31:0]   taddr[NP], twdata[NP];
    logic [2:0]    tsize[NP];

    always_comb begin
        req_valid = tv;
        req_wr    = twr;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        for (int p = 0; p < NP; p++) begin
            req_addr[p*32 +: 32]  = taddr[p];
            req_wdata[p*32 +: 32] = twdata[p];
            req_size[p*3 +: 3]    = tsize[p];
        end
    end

    typedef struct { int cyc; bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [2:0] size; } iss_t;
    typedef struct { int cyc; logic [NP-1:0] port; bit err; logic [31:0] rdata; } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    int   grants[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, rr_ptr = 0, acc_count = 0, rd_due = -1;
    bit   busy = 0;
    logic [31:0] rd_addr = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic bit legal_req(input logic [2:0] s, input logic [31:0] a);
        if (s == 3'd1) return 1;
        if (s == 3'd2) return a[0] == 1'b0;
        if (s == 3'd4) return a[1:0] == 2'b00;
        return 0;
    endfunction

    function automatic logic [NP-1:0] exp_grant(input logic [NP-1:0] v, input int ptr);
        for (int k = 0; k < NP; k++) begin
            int j = (ptr + k) % NP;
            if (v[j]) return NP'(1) << j;
        end
        return '0;
    endfunction

    always @(posedge CLK) cyc = cyc + 1;

    always @(posedge CLK) begin
        #1;
        mem_rdata = (cyc == rd_due) ? memfn(rd_addr) : 32'h0BAD_F00D;
    end

    logic [NP-1:0] g;
    int   idx;
    bit   lg;
    iss_t ie;
    rsp_t re;

    always @(negedge CLK) begin
        if (!Reset) begin
            exp_iss.delete();
            exp_rsp.delete();
            busy   = 0;
            rr_ptr = 0;
            rd_due = -1;
        end else begin
            if (busy) begin
                if (req_valid != 0) check("ready_busy", req_ready, 0);
            end else if (req_valid != 0 || req_ready != 0) begin
                g = exp_grant(req_valid, rr_ptr);
                check("req_ready", req_ready, g);
                if ((req_valid & req_ready) != 0 && g != 0) begin
                    idx = 0;
                    for (int k = 0; k < NP; k++) if (g[k]) idx = k;
                    lg = legal_req(tsize[idx], taddr[idx]);
                    if (lg) begin
                        ie = '{cyc + 1, !twr[idx], twr[idx], taddr[idx], twdata[idx], tsize[idx]};
                        exp_iss.push_back(ie);
                    end
                    re.cyc   = cyc + ((lg && !twr[idx]) ? 1 + RL : 2);
                    re.port  = g;
                    re.err   = !lg;
                    re.rdata = (lg && !twr[idx]) ? memfn(taddr[idx]) : 32'h0;
                    exp_rsp.push_back(re);
                    busy   = 1;
                    rr_ptr = (idx + 1) % NP;
                    grants.push_back(idx);
                    acc_count++;
                end
            end
            if (mem_rd_en || mem_wr_en) begin
                if (exp_iss.size() == 0) begin
                    check("mem_unexpected", {mem_rd_en, mem_wr_en}, 0);
                end else begin
                    ie = exp_iss.pop_front();
                    check("iss_cycle", cyc, ie.cyc);
                    check("iss_kind", {mem_rd_en, mem_wr_en}, {ie.rd, ie.wr});
                    check("iss_addr", mem_addr, ie.addr);
                    check("iss_wdata", mem_wdata, ie.wdata);
                    check("iss_size", mem_size, ie.size);
                    if (mem_rd_en) begin
                        rd_due  = cyc + RL;
                        rd_addr = mem_addr;
                    end
                end
            end else begin
                check("mem_idle_zero", {mem_addr, mem_wdata, mem_size}, 0);
            end
            if (rsp_valid != 0) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    re = exp_rsp.pop_front();
                    check("rsp_cycle", cyc, re.cyc);
                    check("rsp_port", rsp_valid, re.port);
                    check("rsp_err", rsp_err, re.err);
                    check("rsp_rdata", rsp_rdata, re.rdata);
                    busy = 0;
                end
            end
        end
    end

    task automatic set_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        twr[p]    = wr;
        taddr[p]  = a;
        twdata[p] = d;
        tsize[p]  = s;
        tv[p]     = 1'b1;
    endtask

    task automatic wait_accepts(input int target);
        for (int i = 0; i < 200 && acc_count < target; i++) @(posedge CLK);
        if (acc_count < target) check("accept_timeout", acc_count, target);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(posedge CLK);
        if (busy) check("idle_timeout", busy, 0);
        #1;
    endtask

    task automatic single(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        @(posedge CLK);
        #1;
        set_req(p, wr, a, d, s);
        wait_accepts(acc_count + 1);
        tv[p] = 1'b0;
        wait_idle();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_rdata, rsp_err}, 0);
        check({tag, "_mem_en"}, {mem_rd_en, mem_wr_en}, 0);
        check({tag, "_mem_bus"}, {mem_addr, mem_wdata, mem_size}, 0);
    endtask

    int base;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        tv = '0; twr = '0; mem_rdata = '0;
        for (int p = 0; p < NP; p++) begin
            taddr[p] = '0; twdata[p] = '0; tsize[p] = SZ_WORD;
        end
        tv[0] = 1'b1;
        tv[1] = 1'b1;
        repeat (3) @(negedge CLK);
        reset_checks("rst");
        @(posedge CLK);
        #1;
        tv = '0;
        Reset = 1'b1;

        single(0, 0, 32'h10, 32'h0, SZ_WORD);
        single(2, 1, 32'h21, 32'h1234_5678, SZ_BYTE);
        single(3, 0, 32'h42, 32'h0, SZ_HALF);
        single(1, 0, 32'h33, 32'h0, SZ_BYTE);
        single(1, 1, 32'h40, 32'hCAFE_F00D, SZ_WORD);
        single(1, 0, 32'h13, 32'h0, SZ_WORD);
        single(0, 1, 32'h20, 32'h55, 3'd3);
        single(2, 0, 32'h41, 32'h0, SZ_HALF);
        single(3, 1, 32'h08, 32'h0, 3'd0);

        // port 1 requests briefly while port 3 is being served, then withdraws
        @(posedge CLK);
        #1;
        set_req(3, 1, 32'h60, 32'h7777_0001, SZ_WORD);
        wait_accepts(acc_count + 1);
        tv[3] = 1'b0;
        set_req(1, 1, 32'h64, 32'h7777_0002, SZ_WORD);
        @(posedge CLK);
        #1;
        tv[1] = 1'b0;
        wait_idle();

        base = grants.size();
        @(posedge CLK);
        #1;
        set_req(0, 1, 32'h200, 32'hA0A0_0000, SZ_WORD);
        set_req(1, 1, 32'h300, 32'hB1B1_1111, SZ_WORD);
        wait_accepts(acc_count + 4);
        tv = '0;
        wait_idle();
        for (int k = 0; k < 4; k++) check("alt_order", grants[base + k], k % 2);

        @(posedge CLK);
        #1;
        set_req(2, 0, 32'h80, 32'h0, SZ_WORD);
        wait_accepts(acc_count + 1);
        tv[2] = 1'b0;
        @(posedge CLK);
        #3;
        tv[0] = 1'b1;
        tv[1] = 1'b1;
        Reset = 1'b0;
        #1;
        reset_checks("rst_wait");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        tv = '0;
        Reset = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            check("stale_rsp", rsp_valid, 0);
            check("stale_mem_en", {mem_rd_en, mem_wr_en}, 0);
        end

        base = grants.size();
        @(posedge CLK);
        #1;
        set_req(0, 0, 32'h100, 32'h0, SZ_WORD);
        set_req(1, 1, 32'h104, 32'h1111_2222, SZ_WORD);
        set_req(2, 0, 32'h108, 32'h0, SZ_WORD);
        set_req(3, 1, 32'h10A, 32'h3333_4444, SZ_HALF);
        wait_accepts(acc_count + 8);
        tv = '0;
        wait_idle();
        for (int k = 0; k < 8; k++) check("rr4_order", grants[base + k], k % 4);

        repeat (3) @(posedge CLK);
        check("sb_empty", exp_rsp.size() + exp_iss.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
